// File: rtl/aes_ctr_sequencer.sv
// Purpose: CTR-mode sequencer around an external combinational AES-128 core (key + counter block out, keystream in).
// Latency: out_valid rises SETTLE_CYCLES edges after acceptance; one block in flight, spacing SETTLE_CYCLES+2 cycles.
// Backpressure: result held in HOLD until out_ready; in_ready low whenever busy or a key/iv load is pending.
module aes_ctr_sequencer #(
    parameter int N             = 128,
    parameter int Nr            = 10,
    parameter int Nk            = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           key_load,
    input  logic [N-1:0]   key_in,
    input  logic           iv_load,
    input  logic [127:0]   iv_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic [127:0]   core_in,
    output logic [N-1:0]   core_key,
    input  logic [127:0]   core_out,
    output logic           busy,
    output logic           key_valid
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || N != 32 * Nk || Nr != Nk + 6) begin : g_cfg_check
        $error("aes_ctr_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   key_reg;
    logic [127:0]   ctr_reg;
    logic [127:0]   data_reg;
    logic [3:0]     settle_cnt;
    logic           accept;
    logic           capture;
    logic           release_blk;
    logic           idle;

    assign idle     = (state == S_IDLE);
    assign in_ready = idle & key_valid & ~key_load & ~iv_load;
    assign busy     = ~idle;
    assign core_key = key_reg;
    assign core_in  = ctr_reg;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        release_blk = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (settle_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    release_blk = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            key_reg    <= '0;
            key_valid  <= 1'b0;
            ctr_reg    <= '0;
            data_reg   <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state <= state_nxt;

            if (idle && key_load) begin
                key_reg   <= key_in;
                key_valid <= 1'b1;
            end

            // Only the low word counts; the upper 96 bits are a fixed nonce.
            if (idle && iv_load) begin
                ctr_reg <= iv_in;
            end else if (release_blk) begin
                ctr_reg[31:0] <= ctr_reg[31:0] + 32'd1;
            end

            if (accept) begin
                data_reg   <= in_data;
                settle_cnt <= SETTLE_LOAD;
            end else if (state == S_WAIT && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (capture) begin
                out_data  <= core_out ^ data_reg;
                out_valid <= 1'b1;
            end else if (release_blk) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed bench for aes_ctr_sequencer: table of CTR blocks plus hand-written reset sequences.
module tb_aes_ctr_sequencer;

    localparam int N = 128;
    localparam int S = 3;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IVW = 128'hffeeddccbbaa998877665544ffffffff;

    logic           clk = 1'b0;
    logic           rst;
    logic           key_load;
    logic [N-1:0]   key_in;
    logic           iv_load;
    logic [127:0]   iv_in;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [127:0]   core_in;
    logic [N-1:0]   core_key;
    logic [127:0]   core_out;
    logic           busy;
    logic           key_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_ctr_sequencer #(.N(N), .Nr(10), .Nk(4), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .iv_load   (iv_load),
        .iv_in     (iv_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .core_in   (core_in),
        .core_key  (core_key),
        .core_out  (core_out),
        .busy      (busy),
        .key_valid (key_valid)
    );

    // Stand-in for the AES core: the FIPS-197 pair is exact, everything else is a keyed scramble.
    function automatic logic [127:0] fake_core(input logic [127:0] k, input logic [127:0] c);
        if (k == K1 && c == IV1)
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        return {c[95:0], c[127:96]} ^ {k[63:0], k[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    assign core_out = fake_core(core_key, core_in);

    typedef struct {
        bit           do_key;
        bit           do_iv;
        bit           same;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] din;
        int           hold;
        logic [127:0] exp_ci;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        logic rdy_seen;
        key_in  = v.key;
        iv_in   = v.iv;
        key_load = v.do_key;
        iv_load  = v.do_iv;
        if (v.do_key || v.do_iv) begin
            if (v.same) begin
                in_valid = 1'b1;
                in_data  = v.din;
                #1;
                chk1("load_blocks_ready", in_ready, 1'b0);
            end
            tick();
            key_load = 1'b0;
            iv_load  = 1'b0;
            chk("load_key", core_key, v.key);
            if (v.same) chk1("load_no_accept", busy, 1'b0);
        end
        in_valid = 1'b1;
        in_data  = v.din;
        #1;
        chk1("in_ready_idle", in_ready, 1'b1);
        tick();
        in_data   = ~v.din;
        out_ready = (v.hold == 0);
        chk1("busy_wait", busy, 1'b1);
        chk("core_in", core_in, v.exp_ci);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(S));
        chk("out_data", out_data, v.exp_out);
        for (int i = 0; i < v.hold; i++) begin
            key_load = (i == 2);
            iv_load  = (i == 5);
            key_in   = ~v.key;
            iv_in    = ~v.iv;
            rdy_seen |= in_ready;
            tick();
            chk1("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, v.exp_out);
            chk("hold_ctr", core_in, v.exp_ci);
            chk("hold_key", core_key, v.key);
        end
        key_load = 1'b0;
        iv_load  = 1'b0;
        rdy_seen |= in_ready;
        chk1("in_ready_busy", rdy_seen, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("release_valid", out_valid, 1'b0);
        chk1("release_busy", busy, 1'b0);
    endtask

    task automatic load_and_accept(input logic [127:0] din);
        key_load = 1'b1; key_in = K1;
        iv_load  = 1'b1; iv_in  = IV1;
        tick();
        key_load = 1'b0;
        iv_load  = 1'b0;
        in_valid = 1'b1;
        in_data  = din;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        vecs[0] = '{1, 1, 0, K1, IV1, 128'h0, 0, IV1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{0, 0, 0, K1, IV1, 128'ha5a5a5a5_5a5a5a5a_a5a5a5a5_5a5a5a5a, 0,
                    128'h00112233445566778899aabbccddef00, 128'h0};
        vecs[2] = '{0, 1, 0, K1, IVW, 128'h0123456789abcdeffedcba9876543210, 10, IVW, 128'h0};
        vecs[3] = '{0, 0, 0, K1, IVW, 128'hdeadbeef_00000000_cafef00d_12345678, 0,
                    128'hffeeddccbbaa99887766554400000000, 128'h0};
        vecs[4] = '{1, 0, 1, K2, IVW, 128'h3243f6a8885a308d313198a2e0370734, 0,
                    128'hffeeddccbbaa99887766554400000001, 128'h0};
        vecs[5] = '{0, 1, 1, K2, 128'h0, 128'hffffffff_ffffffff_00000000_00000001, 0, 128'h0, 128'h0};
        for (int i = 1; i < 6; i++)
            vecs[i].exp_out = vecs[i].din ^ fake_core(vecs[i].key, vecs[i].exp_ci);

        rst = 1'b1; key_load = 1'b0; key_in = '0; iv_load = 1'b0; iv_in = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_key_valid", key_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_core_in", core_in, 128'h0);
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_out_data", out_data, 128'h0);

        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk1("no_key_ready", in_ready, 1'b0);
            tick();
        end
        chk1("no_key_busy", busy, 1'b0);
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // Reset while waiting for the core to settle.
        load_and_accept(128'h1111);
        chk1("mid_wait_busy", busy, 1'b1);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk1("rstw_out_valid", out_valid, 1'b0);
        chk1("rstw_key_valid", key_valid, 1'b0);
        chk("rstw_core_in", core_in, 128'h0);
        chk1("rstw_busy", busy, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("rstw_no_accept", busy, 1'b0);
        end
        in_valid = 1'b0;

        // Reset while a result is held, with out_ready offered on the same edge.
        load_and_accept(128'h2222);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk1("rsth_reached_hold", out_valid, 1'b1);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        chk1("rsth_out_valid", out_valid, 1'b0);
        chk1("rsth_key_valid", key_valid, 1'b0);
        chk("rsth_core_in", core_in, 128'h0);
        chk1("rsth_busy", busy, 1'b0);
        chk("rsth_out_data", out_data, 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
